// File: rtl/uart_tx_seq_if.sv
// ----------------------------------------------------------------------------
// uart_tx_seq_if
//
// Purpose: bundles the two buses of the UART TX sequencer: the upstream byte
// stream (valid/ready) and the register write port toward the UART core.
//
// Signals:
//   s_data_i     [7:0]   byte offered by the upstream source
//   s_valid_i            byte valid, held stable until accepted
//   s_ready_o            sequencer accepts the byte this cycle
//   reg_addr_o   [11:0]  core register address (0 outside write cycles)
//   reg_wdata_o  [31:0]  core register write data (0 outside write cycles)
//   reg_we_o             single-cycle register write strobe
//
// Modports:
//   master - the sequencer (consumes the stream, drives the register port)
//   slave  - the environment (byte source and UART core)
// ----------------------------------------------------------------------------
interface uart_tx_seq_if;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [11:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_we_o;

    modport master (
        input  s_data_i, s_valid_i,
        output s_ready_o, reg_addr_o, reg_wdata_o, reg_we_o
    );

    modport slave (
        output s_data_i, s_valid_i,
        input  s_ready_o, reg_addr_o, reg_wdata_o, reg_we_o
    );
endinterface

// File: rtl/uart_tx_seq.sv
// ----------------------------------------------------------------------------
// uart_tx_seq
//
// Purpose: register-port sequencer in front of the UART core. It collects
// bytes from a valid/ready stream into bursts of up to MAX_BURST bytes. For
// each burst it programs the baud divisor, enables TX-FIFO loading, writes the
// bytes, programs the FIFO level, starts transmission, and then waits for the
// core's transmit-complete interrupt. Every register write lasts one cycle and
// is followed by one idle gap cycle.
//
// Parameters:
//   MAX_BURST    bytes per burst before a forced flush (1..7)
//   IDLE_CYCLES  consecutive empty load slots before a partial burst flushes
//   TX_TIMEOUT   WAIT_TX watchdog limit in cycles (only with the macro below)
//
// Build option:
//   UART_TX_SEQ_TIMEOUT_EN - when defined, a WAIT_TX watchdog is built; on
//   expiry err_timeout_o is set (sticky until rst_i) and the burst is stopped.
//   When undefined, WAIT_TX waits indefinitely and err_timeout_o is 0.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous, active-high reset
//   baud_i  [15:0] clocks-per-bit, captured when a burst starts
//   intr_tx_i      core transmit-complete interrupt (only looked at in WAIT_TX)
//   busy_o         high whenever the sequencer is not idle
//   err_timeout_o  sticky watchdog error
//   bus            stream input and core register write port (master side)
// ----------------------------------------------------------------------------
module uart_tx_seq #(
    parameter int MAX_BURST   = 7,
    parameter int IDLE_CYCLES = 64
`ifdef UART_TX_SEQ_TIMEOUT_EN
    ,
    parameter int TX_TIMEOUT  = 1000000
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [15:0]   baud_i,
    input  logic          intr_tx_i,
    output logic          busy_o,
    output logic          err_timeout_o,
    uart_tx_seq_if.master bus
);
    localparam int                IDLE_W   = $clog2(IDLE_CYCLES + 1);
    localparam logic [2:0]        MAX_CNT  = 3'(MAX_BURST);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    localparam logic [11:0] ADDR_BAUD   = 12'h000;
    localparam logic [11:0] ADDR_TXDATA = 12'h004;
    localparam logic [11:0] ADDR_FEN    = 12'h014;
    localparam logic [11:0] ADDR_LEVEL  = 12'h018;
    localparam logic [11:0] ADDR_START  = 12'h01C;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_BAUD,
        S_CFG_FEN,
        S_LOAD,
        S_FEN_OFF,
        S_CFG_LEVEL,
        S_START,
        S_WAIT_TX,
        S_STOP
    } state_t;

    state_t            r_state, w_next_state;
    logic              r_gap, w_next_gap;     // 0: write/slot cycle, 1: gap cycle
    logic [2:0]        r_count, w_next_count; // bytes written in this burst
    logic [IDLE_W-1:0] r_idle, w_next_idle;   // consecutive empty load slots
    logic [15:0]       r_baud;
    logic              w_expire;

    logic              w_ready;
    logic              w_we;
    logic [11:0]       w_addr;
    logic [31:0]       w_wdata;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred; blocking '=' is
    // correct for this purely combinational block.
    always_comb begin
        w_next_state = r_state;
        w_next_gap   = ~r_gap;
        w_next_count = r_count;
        w_next_idle  = r_idle;
        w_ready      = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;

        unique case (r_state)
            S_IDLE: begin
                w_next_gap = 1'b0;
                if (bus.s_valid_i) w_next_state = S_CFG_BAUD;
            end
            S_CFG_BAUD: begin
                if (!r_gap) begin
                    w_we    = 1'b1;
                    w_addr  = ADDR_BAUD;
                    w_wdata = {16'd0, r_baud};
                end else begin
                    w_next_state = S_CFG_FEN;
                end
            end
            S_CFG_FEN: begin
                if (!r_gap) begin
                    w_we    = 1'b1;
                    w_addr  = ADDR_FEN;
                    w_wdata = 32'd1;
                end else begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!r_gap) begin
                    // Slot cycle: a byte may be accepted and written here.
                    w_ready = (r_count < MAX_CNT);
                    if (bus.s_valid_i && w_ready) begin
                        w_we         = 1'b1;
                        w_addr       = ADDR_TXDATA;
                        w_wdata      = {24'd0, bus.s_data_i};
                        w_next_count = r_count + 3'd1;
                        w_next_idle  = '0;
                    end else if (r_idle != IDLE_MAX) begin
                        // Saturate so a long stall cannot wrap the counter.
                        w_next_idle = r_idle + IDLE_W'(1);
                    end
                end else if ((r_count == MAX_CNT) ||
                             ((r_count != 3'd0) && (r_idle == IDLE_MAX))) begin
                    w_next_state = S_FEN_OFF;
                end
            end
            S_FEN_OFF: begin
                if (!r_gap) begin
                    w_we   = 1'b1;
                    w_addr = ADDR_FEN;
                end else begin
                    w_next_state = S_CFG_LEVEL;
                end
            end
            S_CFG_LEVEL: begin
                if (!r_gap) begin
                    w_we    = 1'b1;
                    w_addr  = ADDR_LEVEL;
                    w_wdata = {29'd0, r_count};
                end else begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (!r_gap) begin
                    w_we    = 1'b1;
                    w_addr  = ADDR_START;
                    w_wdata = 32'd1;
                end else begin
                    w_next_state = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                w_next_gap = 1'b0;
                if (intr_tx_i || w_expire) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (!r_gap) begin
                    w_we   = 1'b1;
                    w_addr = ADDR_START;
                end else begin
                    w_next_count = '0;
                    w_next_idle  = '0;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_gap   = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_gap   <= 1'b0;
            r_count <= '0;
            r_idle  <= '0;
            r_baud  <= '0;
        end else begin
            r_state <= w_next_state;
            r_gap   <= w_next_gap;
            r_count <= w_next_count;
            r_idle  <= w_next_idle;
            if ((r_state == S_IDLE) && bus.s_valid_i) r_baud <= baud_i;
        end
    end

`ifdef UART_TX_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TX_TIMEOUT + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_err;

    // r_wd counts cycles already spent in WAIT_TX, so the last allowed cycle
    // is the TX_TIMEOUT-th one and the error is visible TX_TIMEOUT cycles
    // after WAIT_TX entry.
    assign w_expire = (r_state == S_WAIT_TX) && (r_wd == WD_W'(TX_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd <= (r_state == S_WAIT_TX) ? r_wd + WD_W'(1) : '0;
            // A completion interrupt in the expiry cycle takes precedence.
            if (w_expire && !intr_tx_i) r_err <= 1'b1;
        end
    end

    assign err_timeout_o = r_err;
`else
    assign w_expire      = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    assign bus.s_ready_o   = w_ready;
    assign bus.reg_we_o    = w_we;
    assign bus.reg_addr_o  = w_addr;
    assign bus.reg_wdata_o = w_wdata;
    assign busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_seq.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_seq
//
// Directed testbench for uart_tx_seq (MAX_BURST=7, IDLE_CYCLES=64, and
// TX_TIMEOUT=100 when UART_TX_SEQ_TIMEOUT_EN is defined). A negedge monitor
// logs every register write with its cycle number and tracks the write/gap
// and ready rules; each scenario compares the log against a hand-built list
// of (cycle offset, address, data) relative to the cycle in which s_valid_i
// was first presented in IDLE.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_seq;

    logic        clk_i     = 1'b0;
    logic        rst_i     = 1'b1;
    logic [15:0] baud_i    = 16'h0000;
    logic        intr_tx_i = 1'b0;
    logic        busy_o;
    logic        err_timeout_o;

    uart_tx_seq_if tb_if ();

`ifdef UART_TX_SEQ_TIMEOUT_EN
    uart_tx_seq #(.MAX_BURST(7), .IDLE_CYCLES(64), .TX_TIMEOUT(100)) dut (
`else
    uart_tx_seq #(.MAX_BURST(7), .IDLE_CYCLES(64)) dut (
`endif
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .baud_i        (baud_i),
        .intr_tx_i     (intr_tx_i),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o),
        .bus           (tb_if)
    );

    always #5 clk_i = ~clk_i;

    int n_checks  = 0;
    int n_errors  = 0;
    int rule_viol = 0;
    int cyc       = 0;

    always @(posedge clk_i) cyc = cyc + 1;

    // Observed and expected register writes.
    int          wr_cyc[$];
    logic [11:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          exp_off[$];
    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];

    logic prev_we    = 1'b0;
    logic prev_ready = 1'b0;

    // Write-port monitor: logs writes, counts rule violations (back-to-back
    // writes, nonzero address/data on non-write cycles, byte writes without a
    // handshake, s_ready_o high on two consecutive cycles).
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_we    = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (tb_if.reg_we_o) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(tb_if.reg_addr_o);
                wr_data.push_back(tb_if.reg_wdata_o);
                if (prev_we) rule_viol++;
                if (tb_if.reg_addr_o == 12'h004 && !(tb_if.s_valid_i && tb_if.s_ready_o))
                    rule_viol++;
            end else if (tb_if.reg_addr_o != 12'h000 || tb_if.reg_wdata_o != 32'h0) begin
                rule_viol++;
            end
            if (tb_if.s_ready_o && prev_ready) rule_viol++;
            prev_we    = tb_if.reg_we_o;
            prev_ready = tb_if.s_ready_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_intr();
        intr_tx_i = 1'b1;
        tick();
        intr_tx_i = 1'b0;
    endtask

    task automatic exp_wr(input int off, input logic [11:0] a, input logic [31:0] d);
        exp_off.push_back(off);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic compare_writes(input string name, input int t0);
        int n;
        check({name, "_nwrites"}, 64'(wr_addr.size()), 64'(exp_addr.size()));
        n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_wr%0d_addr", name, i), 64'(wr_addr[i]), 64'(exp_addr[i]));
            check($sformatf("%s_wr%0d_data", name, i), 64'(wr_data[i]), 64'(exp_data[i]));
            check($sformatf("%s_wr%0d_cyc", name, i), 64'(wr_cyc[i] - t0), 64'(exp_off[i]));
        end
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        exp_off.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    // Offers n bytes starting at 'first'; before byte index stall_at, valid is
    // dropped for stall_len cycles. Returns one cycle after the last accept,
    // with valid low.
    task automatic feed(input logic [7:0] first, input int n, input int stall_at,
                        input int stall_len);
        int budget;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                tb_if.s_valid_i = 1'b0;
                repeat (stall_len) @(posedge clk_i);
                #1;
            end
            tb_if.s_valid_i = 1'b1;
            tb_if.s_data_i  = first + 8'(i);
            budget = 0;
            @(negedge clk_i);
            while (!tb_if.s_ready_o && budget < 400) begin
                @(negedge clk_i);
                budget++;
            end
            check($sformatf("feed_accept_%0d", i), 64'(budget < 400), 64'd1);
            tick();
        end
        tb_if.s_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: run exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "time limit exceeded");
    end

    initial begin
        int t0;
        tb_if.s_valid_i = 1'b0;
        tb_if.s_data_i  = 8'h00;

        // ---------------- reset state ----------------
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        check("rst_we",    64'(tb_if.reg_we_o),    64'd0);
        check("rst_addr",  64'(tb_if.reg_addr_o),  64'd0);
        check("rst_wdata", 64'(tb_if.reg_wdata_o), 64'd0);
        check("rst_ready", 64'(tb_if.s_ready_o),   64'd0);
        check("rst_busy",  64'(busy_o),            64'd0);
        check("rst_err",   64'(err_timeout_o),     64'd0);
        tick();

        // ---------------- full burst 0x11..0x17 ----------------
        baud_i = 16'h0010;
        t0 = cyc;
        feed(8'h11, 7, -1, 0);
        wait_cyc(t0 + 25);
        check("full_wait_busy", 64'(busy_o), 64'd1);
        wait_cyc(t0 + 30);
        pulse_intr();
        wait_cyc(t0 + 32);
        check("full_stop_busy", 64'(busy_o), 64'd1);
        tick();
        check("full_idle_busy", 64'(busy_o), 64'd0);
        exp_wr(1, 12'h000, 32'h10);
        exp_wr(3, 12'h014, 32'h1);
        for (int k = 0; k < 7; k++) exp_wr(5 + 2 * k, 12'h004, 32'h11 + k);
        exp_wr(19, 12'h014, 32'h0);
        exp_wr(21, 12'h018, 32'h7);
        exp_wr(23, 12'h01C, 32'h1);
        exp_wr(31, 12'h01C, 32'h0);
        compare_writes("full", t0);

        // ---------------- interrupt while idle ----------------
        t0 = cyc;
        pulse_intr();
        repeat (3) tick();
        check("idle_intr_busy", 64'(busy_o), 64'd0);
        compare_writes("idle_intr", t0);

        // ---------------- partial burst flushed after 64 empty slots ----------------
        baud_i = 16'h1234;
        t0 = cyc;
        feed(8'h21, 3, -1, 0);
        wait_cyc(t0 + 20);
        pulse_intr();
        check("part_load_intr_busy", 64'(busy_o), 64'd1);
        wait_cyc(t0 + 145);
        check("part_wait_busy", 64'(busy_o), 64'd1);
        wait_cyc(t0 + 150);
        pulse_intr();
        wait_cyc(t0 + 153);
        check("part_idle_busy", 64'(busy_o), 64'd0);
        exp_wr(1, 12'h000, 32'h1234);
        exp_wr(3, 12'h014, 32'h1);
        exp_wr(5, 12'h004, 32'h21);
        exp_wr(7, 12'h004, 32'h22);
        exp_wr(9, 12'h004, 32'h23);
        exp_wr(139, 12'h014, 32'h0);
        exp_wr(141, 12'h018, 32'h3);
        exp_wr(143, 12'h01C, 32'h1);
        exp_wr(151, 12'h01C, 32'h0);
        compare_writes("partial", t0);

        // ---------------- 10-cycle stall mid-burst ----------------
        baud_i = 16'h0003;
        t0 = cyc;
        feed(8'h31, 5, 2, 10);
        wait_cyc(t0 + 160);
        pulse_intr();
        wait_cyc(t0 + 163);
        check("stall_idle_busy", 64'(busy_o), 64'd0);
        exp_wr(1, 12'h000, 32'h3);
        exp_wr(3, 12'h014, 32'h1);
        exp_wr(5, 12'h004, 32'h31);
        exp_wr(7, 12'h004, 32'h32);
        exp_wr(19, 12'h004, 32'h33);
        exp_wr(21, 12'h004, 32'h34);
        exp_wr(23, 12'h004, 32'h35);
        exp_wr(153, 12'h014, 32'h0);
        exp_wr(155, 12'h018, 32'h5);
        exp_wr(157, 12'h01C, 32'h1);
        exp_wr(161, 12'h01C, 32'h0);
        compare_writes("stall", t0);

        // ---------------- WAIT_TX without interrupt ----------------
        baud_i = 16'h0020;
        t0 = cyc;
        feed(8'h41, 7, -1, 0);
        exp_wr(1, 12'h000, 32'h20);
        exp_wr(3, 12'h014, 32'h1);
        for (int k = 0; k < 7; k++) exp_wr(5 + 2 * k, 12'h004, 32'h41 + k);
        exp_wr(19, 12'h014, 32'h0);
        exp_wr(21, 12'h018, 32'h7);
        exp_wr(23, 12'h01C, 32'h1);
`ifdef UART_TX_SEQ_TIMEOUT_EN
        wait_cyc(t0 + 124);
        check("wd_before_err", 64'(err_timeout_o), 64'd0);
        check("wd_before_busy", 64'(busy_o), 64'd1);
        tick();
        check("wd_err_set", 64'(err_timeout_o), 64'd1);
        wait_cyc(t0 + 127);
        check("wd_idle_busy", 64'(busy_o), 64'd0);
        check("wd_err_sticky", 64'(err_timeout_o), 64'd1);
        exp_wr(125, 12'h01C, 32'h0);
`else
        wait_cyc(t0 + 25 + 10000);
        check("nowd_busy", 64'(busy_o), 64'd1);
        check("nowd_err", 64'(err_timeout_o), 64'd0);
        pulse_intr();
        wait_cyc(t0 + 10028);
        check("nowd_idle_busy", 64'(busy_o), 64'd0);
        exp_wr(10026, 12'h01C, 32'h0);
`endif
        compare_writes("wait_tx", t0);

        // ---------------- reset during LOAD after 2 bytes ----------------
        baud_i = 16'h0007;
        t0 = cyc;
        feed(8'h51, 2, -1, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_we",    64'(tb_if.reg_we_o),    64'd0);
        check("mid_rst_addr",  64'(tb_if.reg_addr_o),  64'd0);
        check("mid_rst_wdata", 64'(tb_if.reg_wdata_o), 64'd0);
        check("mid_rst_ready", 64'(tb_if.s_ready_o),   64'd0);
        check("mid_rst_busy",  64'(busy_o),            64'd0);
        check("mid_rst_err",   64'(err_timeout_o),     64'd0);
        exp_wr(1, 12'h000, 32'h7);
        exp_wr(3, 12'h014, 32'h1);
        exp_wr(5, 12'h004, 32'h51);
        exp_wr(7, 12'h004, 32'h52);
        compare_writes("pre_rst", t0);

        baud_i          = 16'hBEEF;
        tb_if.s_valid_i = 1'b1;
        tb_if.s_data_i  = 8'h61;
        tick();
        check("restart_we",    64'(tb_if.reg_we_o),    64'd1);
        check("restart_addr",  64'(tb_if.reg_addr_o),  64'h000);
        check("restart_wdata", 64'(tb_if.reg_wdata_o), 64'h0000BEEF);
        check("restart_busy",  64'(busy_o),            64'd1);
        tb_if.s_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();

        check("bus_rules", 64'(rule_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
